// File: rtl/mem_port_arbiter.sv
// Shares one single-port SRAM between instruction fetch and the MEM-stage data port.
// Each access runs IDLE -> ACCESS (WAIT_STATES+1 cycles) -> DONE, where DONE carries the ready pulse.
module mem_port_arbiter #(
    parameter int WAIT_STATES = 2,
    parameter int ADDR_W      = 16,
    parameter int DATA_BASE   = 1024,
    parameter int MAX_CONSEC  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_ready,
    input  logic              mem_r_en,
    input  logic              mem_w_en,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_ready,
    output logic              if_freeze,
    output logic              mem_freeze,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;
    localparam int CW = $clog2(MAX_CONSEC + 1);

    logic [1:0]        state;
    logic              own_if;
    logic              op_wr;
    logic [ADDR_W-1:0] lat_addr;
    logic [31:0]       lat_wdata;
    logic [3:0]        wait_cnt;
    logic [CW-1:0]     consec_cnt;
    logic              data_req;
    logic              grant_if;
    logic              grant_data;
    logic [31:0]       data_off;
    logic              unused_addr_bits;

    assign data_req   = mem_r_en | mem_w_en;
    // Data normally wins; a fetch starved for MAX_CONSEC data grants gets the next slot.
    assign grant_if   = if_req & (~data_req | (consec_cnt == CW'(MAX_CONSEC)));
    assign grant_data = data_req & ~grant_if;
    assign data_off   = mem_addr - 32'(DATA_BASE);

    assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                                data_off[31:ADDR_W+2], data_off[1:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            own_if     <= 1'b0;
            op_wr      <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            wait_cnt   <= '0;
            consec_cnt <= '0;
            if_rdata   <= '0;
            mem_rdata  <= '0;
            if_ready   <= 1'b0;
            mem_ready  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_if || grant_data) begin
                        state    <= S_ACCESS;
                        own_if   <= grant_if;
                        op_wr    <= grant_data & mem_w_en;
                        lat_addr <= grant_if ? if_addr[ADDR_W+1:2] : data_off[ADDR_W+1:2];
                        wait_cnt <= 4'(WAIT_STATES);
                        if (grant_data)
                            lat_wdata <= mem_wdata;
                        if (grant_data && if_req) begin
                            if (consec_cnt != CW'(MAX_CONSEC))
                                consec_cnt <= consec_cnt + 1'b1;
                        end else begin
                            consec_cnt <= '0;
                        end
                    end
                end
                S_ACCESS: begin
                    if (wait_cnt == 4'd0) begin
                        state <= S_DONE;
                        if (own_if) begin
                            if_ready <= 1'b1;
                            if_rdata <= sram_rdata;
                        end else begin
                            mem_ready <= 1'b1;
                            if (!op_wr)
                                mem_rdata <= sram_rdata;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    state     <= S_IDLE;
                    if_ready  <= 1'b0;
                    mem_ready <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Strobes decode straight from state so an async reset releases the SRAM at once.
    assign sram_ce_n  = ~(state == S_ACCESS);
    assign sram_oe_n  = ~((state == S_ACCESS) & ~op_wr);
    assign sram_we_n  = ~((state == S_ACCESS) & op_wr);
    assign sram_addr  = lat_addr;
    assign sram_wdata = lat_wdata;

    assign if_freeze  = if_req & ~if_ready;
    assign mem_freeze = data_req & ~mem_ready;
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port external SRAM between instruction fetch (IF) and the MEM-stage data port.
- Sequences each access with a programmable wait-state count.
- Returns a one-cycle ready pulse with read data.
- Drives freeze outputs that stall the pipeline while an access is outstanding.
- Sits at the top level beside the hazard unit. Its freeze outputs are OR-ed into the IF freeze and the pipeline-register enables.

Parameters:
- WAIT_STATES, 2: extra SRAM access cycles per transfer (0..15).
- ADDR_W, 16: SRAM word-address width.
- DATA_BASE, 1024: byte offset subtracted from data addresses before word conversion.
- MAX_CONSEC, 4: maximum consecutive data grants while a fetch is pending.

Ports:
- clk input 1: clock, rising edge.
- rst input 1: asynchronous, active-low reset.
- if_req input 1: fetch request; held until if_ready.
- if_addr input 32: fetch byte address.
- if_rdata output 32: fetched instruction; valid while if_ready=1.
- if_ready output 1: one-cycle fetch completion pulse.
- mem_r_en input 1: data read request; held until mem_ready.
- mem_w_en input 1: data write request; held until mem_ready.
- mem_addr input 32: data byte address.
- mem_wdata input 32: store data.
- mem_rdata output 32: load data; valid while mem_ready=1.
- mem_ready output 1: one-cycle data completion pulse.
- if_freeze output 1: if_req & ~if_ready.
- mem_freeze output 1: (mem_r_en|mem_w_en) & ~mem_ready.
- sram_addr output ADDR_W: SRAM word address.
- sram_wdata output 32: SRAM write data.
- sram_rdata input 32: SRAM read data.
- sram_ce_n output 1: chip enable, active low.
- sram_oe_n output 1: output enable, active low.
- sram_we_n output 1: write enable, active low.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - sram_ce_n, sram_oe_n, sram_we_n all = 1.
  - sram_addr=0, sram_wdata=0.
  - if_rdata=0, mem_rdata=0, if_ready=0, mem_ready=0.
  - wait counter=0, consecutive-data counter=0.
  - Reset mid-access aborts the access immediately. No ready pulse is issued.
- States:
  - IDLE: no access in progress.
  - ACCESS: SRAM cycle in progress, counting down wait states.
  - DONE: one-cycle completion, ready pulse asserted.
- IDLE, arbitration:
  - A data request exists if mem_r_en|mem_w_en. It wins over if_req.
  - Exception: if the consecutive-data counter == MAX_CONSEC and if_req=1, IF wins.
  - On grant, latch owner, op (read/write), address and wdata. Go to ACCESS with counter=WAIT_STATES.
  - Address mapping: IF uses if_addr[ADDR_W+1:2]. Data uses (mem_addr-DATA_BASE)[ADDR_W+1:2]. Bits [1:0] are ignored.
  - If mem_r_en and mem_w_en are both 1, the access is a write.
- Consecutive-data counter:
  - Increments on each data grant made while if_req=1, saturating at MAX_CONSEC.
  - Clears on any IF grant.
  - Clears on any grant made while if_req=0.
- ACCESS:
  - sram_ce_n=0.
  - Read: sram_oe_n=0.
  - Write: sram_we_n=0, sram_wdata=latched wdata.
  - sram_addr holds the latched address.
  - Counter decrements each cycle. When counter==0, go to DONE.
- DONE:
  - Read data: sram_rdata is registered into the owner's rdata on the ACCESS→DONE edge.
  - The owner's ready=1 for exactly this cycle. The other port's ready stays 0.
  - sram_ce_n, sram_oe_n, sram_we_n return to 1.
  - Always go to IDLE next cycle.
- Latency:
  - Request seen in IDLE at cycle 0 → ready high in cycle WAIT_STATES+2.
  - Back-to-back accesses cost WAIT_STATES+3 cycles each, because IDLE consumes one cycle.
- Request withdrawn mid-access: the access completes and the ready pulse is still generated. A write is still performed.
- Latched values: if_rdata and mem_rdata hold their last value until overwritten.
- A write completion does not change mem_rdata.
- Ready pulses are registered outputs. The freeze outputs are combinational from the inputs and the ready registers.

Test Plan:
- WAIT_STATES=2. SRAM model pre-loaded word[5]=0xE3A01005. if_req=1, if_addr=0x14 at cycle 0 → sram_oe_n=0 and sram_addr=5 in cycles 1–3; if_ready=1 and if_rdata=0xE3A01005 in cycle 4 only; if_freeze=1 in cycles 0–3.
- mem_w_en=1, mem_addr=1032, mem_wdata=0xDEADBEEF → sram_we_n=0 for 3 cycles at sram_addr=2. Then mem_r_en at 1032 returns mem_rdata=0xDEADBEEF with the mem_ready pulse.
- if_req and mem_r_en asserted in the same cycle → data granted first (mem_ready at cycle 4). IF is granted next, if_ready at cycle 9.
- MAX_CONSEC=4, mem_r_en held high continuously with if_req=1 → 4 data grants, then 1 IF grant, then the pattern repeats. if_ready occurs every 5th completion.
- rst driven low during ACCESS of a write → sram_we_n=1 and sram_ce_n=1 immediately. No mem_ready. After release, state=IDLE and a new request completes normally.
- WAIT_STATES=0 → ready in cycle 2; sram_ce_n low for exactly 1 cycle.
